// File: rtl/ram_pdp_stream_reader.sv
// Burst read master for the pseudo dual-port RAM, streaming words out as valid/ready.
// Optional macro RAM_READER_ABORT_EN adds Abort_i to terminate a burst early.
module ram_pdp_stream_reader #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start_i,
    input  logic [ADDRESS_WIDTH-1:0] StartAddress_i,
    input  logic [ADDRESS_WIDTH:0]   Length_i,
`ifdef RAM_READER_ABORT_EN
    input  logic                     Abort_i,
`endif
    output logic                     Busy_o,
    output logic                     Done_o,
    output logic                     ReadEnable_o,
    output logic [ADDRESS_WIDTH-1:0] ReadAddress_o,
    input  logic [DATA_WIDTH-1:0]    Data_i,
    output logic [DATA_WIDTH-1:0]    Data_o,
    output logic                     Valid_o,
    input  logic                     Ready_i,
    output logic                     Last_o
);

    localparam int FifoDepth = 4;
    localparam logic [ADDRESS_WIDTH:0] RemainOne = 1;
    localparam logic [2:0] OutstandingLimit = 3'd3;

    typedef enum logic [1:0] {
        StateIdle,
        StateRun,
        StateDrain,
        StateDone
    } stateType;

    stateType state;
    stateType nextState;

    logic [ADDRESS_WIDTH-1:0] address;
    logic [ADDRESS_WIDTH:0]   remaining;
    logic                     inFlight;
    logic                     inFlightLast;
    logic [DATA_WIDTH-1:0]    fifoData [FifoDepth];
    logic                     fifoLast [FifoDepth];
    logic [1:0]               wrPtr;
    logic [1:0]               rdPtr;
    logic [2:0]               count;
    logic [2:0]               outstanding;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     abort;
    logic                     fifoValid;
    logic                     headLast;

    assign fifoValid   = (count != 3'd0);
    assign headLast    = fifoLast[rdPtr];
    assign outstanding = count + {2'b00, inFlight};
    assign push        = inFlight;
    assign pop         = fifoValid && Ready_i;

    // Abort only matters while a burst is in progress.
`ifdef RAM_READER_ABORT_EN
    assign abort = Abort_i && ((state == StateRun) || (state == StateDrain));
`else
    assign abort = 1'b0;
`endif

    // Next-state decode and read issue; reads are gated on registered occupancy only.
    always_comb begin
        nextState = state;
        issue     = 1'b0;
        unique case (state)
            StateIdle: begin
                if (Start_i) begin
                    if (Length_i == '0) begin
                        nextState = StateDone;
                    end else begin
                        nextState = StateRun;
                    end
                end
            end
            StateRun: begin
                if ((remaining != '0) && (outstanding < OutstandingLimit)) begin
                    issue = 1'b1;
                end
                if (issue && (remaining == RemainOne)) begin
                    nextState = StateDrain;
                end
            end
            StateDrain: begin
                if (pop && headLast) begin
                    nextState = StateDone;
                end
            end
            StateDone: begin
                nextState = StateIdle;
            end
            default: begin
                nextState = StateIdle;
            end
        endcase
        if (abort) begin
            issue     = 1'b0;
            nextState = StateDone;
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= StateIdle;
        end else begin
            state <= nextState;
        end
    end

    // Burst address and remaining-word counters.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            address   <= '0;
            remaining <= '0;
        end else if ((state == StateIdle) && Start_i && (Length_i != '0)) begin
            address   <= StartAddress_i;
            remaining <= Length_i;
        end else if (issue) begin
            address   <= address + 1'b1;
            remaining <= remaining - RemainOne;
        end
    end

    // Read-latency stage and output FIFO; abort drops everything in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            inFlight     <= 1'b0;
            inFlightLast <= 1'b0;
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                fifoData[i] <= '0;
                fifoLast[i] <= 1'b0;
            end
        end else if (abort) begin
            inFlight     <= 1'b0;
            inFlightLast <= 1'b0;
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
        end else begin
            inFlight     <= issue;
            inFlightLast <= issue && (remaining == RemainOne);
            if (push) begin
                fifoData[wrPtr] <= Data_i;
                fifoLast[wrPtr] <= inFlightLast;
                wrPtr           <= wrPtr + 2'd1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 2'd1;
            end
            if (push && !pop) begin
                count <= count + 3'd1;
            end else if (!push && pop) begin
                count <= count - 3'd1;
            end
        end
    end

    assign Busy_o        = (state != StateIdle);
    assign Done_o        = (state == StateDone);
    assign ReadEnable_o  = issue;
    assign ReadAddress_o = address;
    assign Valid_o       = fifoValid;
    assign Data_o        = fifoValid ? fifoData[rdPtr] : '0;
    assign Last_o        = fifoValid && headLast;

endmodule
